// File: rtl/ln_stage5_writeback.sv
// ---------------------------------------------------------------------------
// ln_stage5_writeback
//
// Collects normalized 64-lane beats coming out of the LayerNorm normalize
// stage into a 4-bank row buffer and drains each bank as a complete row
// over a valid/ready stream.
//
// Write side:
//   Each beat carries an address {bank[1:0], beat[3:0]}. A beat is stored
//   only if its beat index is in range and the target bank is currently
//   free. Out-of-range and not-free writes are dropped and each raises its
//   own sticky error flag. Upstream has no backpressure.
//
// Completion:
//   When every beat of a free bank has been written, the bank is queued in
//   a 4-deep completion FIFO, marked busy (not free) and its fill bitmap is
//   cleared. Several banks completing together are queued lowest first.
//
// Drain side:
//   A three-state FSM pops a bank, then alternates READ (load one beat from
//   the row buffer into the output register) and SEND (hold until the
//   consumer accepts). The final beat's handshake frees the bank again.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_en                   gates input capture only (drain keeps running)
//   i_res_valid/addr/data  incoming normalized beat
//   o_data_flat/o_valid    drained beat and its valid
//   i_ready                consumer ready
//   o_bank/o_beat/o_last   tag of the beat on the output
//   o_bank_free            per-bank "upstream may write" flags
//   o_err_overrun          sticky: write aimed at a bank that is not free
//   o_err_addr             sticky: beat index >= BEATS_PER_ROW
// ---------------------------------------------------------------------------
module ln_stage5_writeback #(
  parameter int BEATS_PER_ROW = 12,
  parameter int N_BANKS       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_res_valid,
  input  logic [5:0]    i_res_addr,
  input  logic [1023:0] i_res_data_flat,
  output logic [1023:0] o_data_flat,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [1:0]    o_bank,
  output logic [3:0]    o_beat,
  output logic          o_last,
  output logic [3:0]    o_bank_free,
  output logic          o_err_overrun,
  output logic          o_err_addr
);

  localparam int DW = 1024;

  // Beat count and last-beat index in the widths they are compared at.
  localparam logic [4:0]  BPR       = 5'(BEATS_PER_ROW);
  localparam logic [3:0]  LAST_BEAT = 4'(BEATS_PER_ROW - 1);
  // Fill bitmap value meaning "every beat of the row has arrived".
  localparam logic [16:0] ONE17     = 17'd1;
  localparam logic [15:0] FULL_MASK = 16'((ONE17 << BEATS_PER_ROW) - ONE17);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Row buffer: 16 beat slots per bank, addressed directly by {bank, beat}.
  // Contents need no reset; a slot is only read after its bank filled up.
  // -------------------------------------------------------------------------
  logic [DW-1:0] mem [N_BANKS*16];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [1:0]                cur_bank_q, cur_bank_d;
  logic [3:0]                cur_beat_q, cur_beat_d;

  logic [N_BANKS-1:0][15:0]  fill_q, fill_d;
  logic [N_BANKS-1:0]        bank_free_q, bank_free_d;

  logic [N_BANKS-1:0][1:0]   fifo_q, fifo_d;
  logic [2:0]                fifo_cnt_q, fifo_cnt_d;

  logic [DW-1:0]             data_q, data_d;
  logic                      valid_q, valid_d;
  logic [1:0]                bank_q, bank_d;
  logic [3:0]                beat_q, beat_d;
  logic                      last_q, last_d;
  logic                      err_overrun_q, err_overrun_d;
  logic                      err_addr_q, err_addr_d;

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  logic       wr_req;
  logic [1:0] wr_bank;
  logic [3:0] wr_beat;
  logic       addr_bad;
  logic       bank_busy;
  logic       wr_en;

  always_comb begin
    wr_req    = i_en & i_res_valid;
    wr_bank   = i_res_addr[5:4];
    wr_beat   = i_res_addr[3:0];
    addr_bad  = ({1'b0, wr_beat} >= BPR);
    // Uses the registered free flag, so a write landing on the same edge a
    // bank is released is still treated as an overrun.
    bank_busy = ~bank_free_q[wr_bank];
    wr_en     = wr_req & ~addr_bad & ~bank_busy;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[i_res_addr] <= i_res_data_flat;
    end
  end

  // -------------------------------------------------------------------------
  // Completion detect: a bank is done when its bitmap is full while it is
  // still marked free (once queued it is no longer free, so it fires once).
  // -------------------------------------------------------------------------
  logic [N_BANKS-1:0] bank_done;

  genvar gi;
  generate
    for (gi = 0; gi < N_BANKS; gi++) begin : g_done
      assign bank_done[gi] = (fill_q[gi] == FULL_MASK) && bank_free_q[gi];
    end
  endgenerate

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      fill_d[b] = fill_q[b];
      if (wr_en && (wr_bank == 2'(b))) begin
        fill_d[b][wr_beat] = 1'b1;
      end
      // Clearing wins over a same-edge write to the completing bank.
      if (bank_done[b]) begin
        fill_d[b] = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drain FSM
  // -------------------------------------------------------------------------
  logic       fifo_pop;
  logic       release_en;
  logic [5:0] rd_addr;

  assign rd_addr = {cur_bank_q, cur_beat_q};

  always_comb begin
    state_d    = state_q;
    cur_bank_d = cur_bank_q;
    cur_beat_d = cur_beat_q;
    data_d     = data_q;
    valid_d    = valid_q;
    bank_d     = bank_q;
    beat_d     = beat_q;
    last_d     = last_q;
    fifo_pop   = 1'b0;
    release_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_cnt_q != 3'd0) begin
          fifo_pop   = 1'b1;
          cur_bank_d = fifo_q[0];
          cur_beat_d = 4'd0;
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        data_d  = mem[rd_addr];
        valid_d = 1'b1;
        bank_d  = cur_bank_q;
        beat_d  = cur_beat_q;
        last_d  = (cur_beat_q == LAST_BEAT);
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            release_en = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cur_beat_d = cur_beat_q + 4'd1;
            state_d    = ST_READ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Completion FIFO: pop first (shift down), then append every bank that
  // completes this edge in ascending order. Every queued or draining bank
  // has its free flag low and completion needs it high, so the occupancy
  // never exceeds N_BANKS and the append pointer stays in range.
  // -------------------------------------------------------------------------
  logic [2:0] push_ptr;

  always_comb begin
    fifo_d   = fifo_q;
    push_ptr = fifo_cnt_q;
    if (fifo_pop) begin
      for (int i = 0; i < N_BANKS - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      push_ptr = fifo_cnt_q - 3'd1;
    end
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_done[b]) begin
        fifo_d[push_ptr[1:0]] = 2'(b);
        push_ptr              = push_ptr + 3'd1;
      end
    end
    fifo_cnt_d = push_ptr;
  end

  // -------------------------------------------------------------------------
  // Free flags and sticky errors
  // -------------------------------------------------------------------------
  always_comb begin
    bank_free_d = bank_free_q & ~bank_done;
    // The releasing bank is never the completing one (it is not free).
    if (release_en) begin
      bank_free_d[cur_bank_q] = 1'b1;
    end
    err_addr_d    = err_addr_q    | (wr_req & addr_bad);
    err_overrun_d = err_overrun_q | (wr_req & ~addr_bad & bank_busy);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      cur_bank_q    <= 2'd0;
      cur_beat_q    <= 4'd0;
      fill_q        <= '0;
      bank_free_q   <= '1;
      fifo_q        <= '0;
      fifo_cnt_q    <= 3'd0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      bank_q        <= 2'd0;
      beat_q        <= 4'd0;
      last_q        <= 1'b0;
      err_overrun_q <= 1'b0;
      err_addr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_bank_q    <= cur_bank_d;
      cur_beat_q    <= cur_beat_d;
      fill_q        <= fill_d;
      bank_free_q   <= bank_free_d;
      fifo_q        <= fifo_d;
      fifo_cnt_q    <= fifo_cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      bank_q        <= bank_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
      err_overrun_q <= err_overrun_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign o_data_flat   = data_q;
  assign o_valid       = valid_q;
  assign o_bank        = bank_q;
  assign o_beat        = beat_q;
  assign o_last        = last_q;
  assign o_bank_free   = bank_free_q;
  assign o_err_overrun = err_overrun_q;
  assign o_err_addr    = err_addr_q;

endmodule

// File: tb/tb_ln_stage5_writeback.sv
// ---------------------------------------------------------------------------
// tb_ln_stage5_writeback
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (row store, per-bank "beats seen" sets, a queue of completed banks and a
// row cursor with its output register) predicts every output after each
// clock edge; the main process compares all outputs on every cycle, and a
// few literal expectations pin latency, ordering and error behaviour.
// ---------------------------------------------------------------------------
module tb_ln_stage5_writeback;

  localparam int BPR = 12;
  localparam logic [15:0] FULL = 16'h0FFF;

  logic          i_clk;
  logic          i_rst;
  logic          i_en;
  logic          i_res_valid;
  logic [5:0]    i_res_addr;
  logic [1023:0] i_res_data_flat;
  logic [1023:0] o_data_flat;
  logic          o_valid;
  logic          i_ready;
  logic [1:0]    o_bank;
  logic [3:0]    o_beat;
  logic          o_last;
  logic [3:0]    o_bank_free;
  logic          o_err_overrun;
  logic          o_err_addr;

  ln_stage5_writeback #(.BEATS_PER_ROW(BPR), .N_BANKS(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .i_res_valid    (i_res_valid),
    .i_res_addr     (i_res_addr),
    .i_res_data_flat(i_res_data_flat),
    .o_data_flat    (o_data_flat),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_bank         (o_bank),
    .o_beat         (o_beat),
    .o_last         (o_last),
    .o_bank_free    (o_bank_free),
    .o_err_overrun  (o_err_overrun),
    .o_err_addr     (o_err_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit verbose  = 1'b1;

  // ------------------------------- model ----------------------------------
  logic [1023:0] m_mem [4][16];
  logic [15:0]   m_fill [4];
  logic [3:0]    m_free;
  int            m_q[$];
  bit            m_busy;      // a row is being streamed out
  bit            m_show;      // next edge loads the cursor beat to output
  int            m_row;
  int            m_idx;
  logic          m_valid;
  logic [1023:0] m_data;
  logic [1:0]    m_bank;
  logic [3:0]    m_beat;
  logic          m_last;
  logic          m_err_a;
  logic          m_err_o;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) m_fill[b] = '0;
    m_free  = 4'hF;
    m_q.delete();
    m_busy  = 0;
    m_show  = 0;
    m_row   = 0;
    m_idx   = 0;
    m_valid = 0;
    m_data  = '0;
    m_bank  = 0;
    m_beat  = 0;
    m_last  = 0;
    m_err_a = 0;
    m_err_o = 0;
  endfunction

  // Advances the model across one clock edge with the given inputs.
  function automatic void model_step(input logic en, input logic vld,
                                     input logic [5:0] addr,
                                     input logic [1023:0] data,
                                     input logic rdy);
    logic [3:0] free_old;
    bit         done [4];
    int         b;
    int         t;
    free_old = m_free;
    // Output side, using the row store as it was before this edge.
    if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        if (m_last) begin
          m_free[m_row] = 1'b1;
          m_busy        = 0;
        end else begin
          m_idx++;
          m_show = 1;
        end
      end
    end else if (m_show) begin
      m_data  = m_mem[m_row][m_idx];
      m_valid = 1;
      m_bank  = 2'(m_row);
      m_beat  = 4'(m_idx);
      m_last  = (m_idx == BPR - 1);
      m_show  = 0;
    end else if (!m_busy && m_q.size() > 0) begin
      m_row  = m_q.pop_front();
      m_idx  = 0;
      m_busy = 1;
      m_show = 1;
    end
    // Rows that were already complete get queued, lowest bank first.
    for (int k = 0; k < 4; k++) begin
      done[k] = (m_fill[k] == FULL) && free_old[k];
      if (done[k]) begin
        m_q.push_back(k);
        m_free[k] = 1'b0;
      end
    end
    // Input capture.
    if (en && vld) begin
      b = int'(addr[5:4]);
      t = int'(addr[3:0]);
      if (t >= BPR) m_err_a = 1;
      else if (!free_old[b]) m_err_o = 1;
      else begin
        m_mem[b][t]  = data;
        m_fill[b][t] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) if (done[k]) m_fill[k] = '0;
  endfunction

  // ------------------------------- checks ---------------------------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    int lane;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      lane = 0;
      for (int k = 63; k >= 0; k--) if (got[16*k +: 16] !== exp[16*k +: 16]) lane = k;
      $display("FAIL %s cyc=%0d lane=%0d got=%h expected=%h", name, cyc, lane,
               got[16*lane +: 16], exp[16*lane +: 16]);
    end
  endtask

  task automatic compare_all();
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_bank_free", 32'(o_bank_free), 32'(m_free));
    chk("o_err_addr", 32'(o_err_addr), 32'(m_err_a));
    chk("o_err_overrun", 32'(o_err_overrun), 32'(m_err_o));
    chk("o_bank", 32'(o_bank), 32'(m_bank));
    chk("o_beat", 32'(o_beat), 32'(m_beat));
    chk("o_last", 32'(o_last), 32'(m_last));
    chk_data("o_data_flat", o_data_flat, m_data);
  endtask

  // One clock: compare at the falling edge, then drive the next inputs and
  // advance the model across the coming rising edge.
  task automatic cycle(input logic en, input logic vld, input logic [5:0] addr,
                       input logic [1023:0] data, input logic rdy);
    @(negedge i_clk);
    cyc++;
    compare_all();
    i_rst           = 1'b0;
    i_en            = en;
    i_res_valid     = vld;
    i_res_addr      = addr;
    i_res_data_flat = data;
    i_ready         = rdy;
    if (verbose && o_valid && rdy)
      $display("beat out: bank=%0d beat=%0d last=%0d lane0=%h", o_bank, o_beat, o_last,
               o_data_flat[15:0]);
    model_step(en, vld, addr, data, rdy);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 6'd0, '0, rdy);
  endtask

  function automatic logic [1023:0] lane_data(input int base);
    logic [1023:0] v;
    for (int k = 0; k < 64; k++) v[16*k +: 16] = 16'(base + k);
    return v;
  endfunction

  function automatic logic [1023:0] rand_data();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic fill_row(input int bank, input logic rdy);
    for (int t = 0; t < BPR; t++)
      cycle(1'b1, 1'b1, {2'(bank), 4'(t)}, lane_data(16 * t), rdy);
  endtask

  task automatic drain(input int max_cycles);
    bit settled;
    settled = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_busy && !m_valid && m_q.size() == 0 &&
          !((m_fill[0] == FULL && m_free[0]) || (m_fill[1] == FULL && m_free[1]) ||
            (m_fill[2] == FULL && m_free[2]) || (m_fill[3] == FULL && m_free[3]))) begin
        settled = 1;
        break;
      end
      idle(1'b1);
    end
    chk("drain_settles", 32'(settled), 32'd1);
  endtask

  // ------------------------------ stimulus --------------------------------
  initial begin
    int w, first_v, last_v, n_v, n_hs, stall_left, first_bank, dup_seen;
    bit stalled;
    logic [1023:0] d;
    logic [5:0] a;
    int b, t, r;
    logic en, vld, rdy;

    i_rst = 1'b0; i_en = 0; i_res_valid = 0; i_res_addr = 0;
    i_res_data_flat = '0; i_ready = 0;
    #1 i_rst = 1'b1;
    model_reset();
    #1;
    chk("reset_bank_free", 32'(o_bank_free), 32'hF);
    chk("reset_valid", 32'(o_valid), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Single row, bank 0, consumer always ready.
    for (int t2 = 0; t2 < BPR - 1; t2++)
      cycle(1'b1, 1'b1, {2'd0, 4'(t2)}, lane_data(16 * t2), 1'b1);
    cycle(1'b1, 1'b1, {2'd0, 4'd11}, lane_data(16 * 11), 1'b1);
    w = cyc; first_v = -1; last_v = -1; n_v = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1'b1);
      if (cyc == w + 2) chk("free0_after_complete", 32'(o_bank_free[0]), 32'd0);
      if (o_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        n_v++;
      end
    end
    chk("latency_edges", 32'(first_v - w - 1), 32'd3);
    chk("row_beat_count", 32'(n_v), 32'd12);
    chk("row_span", 32'(last_v - first_v), 32'd22);
    chk("free0_after_drain", 32'(o_bank_free), 32'hF);

    // Interleaved, reverse order: banks 1 and 2, bank 1 completes first.
    for (int t2 = BPR - 1; t2 >= 0; t2--) begin
      cycle(1'b1, 1'b1, {2'd1, 4'(t2)}, rand_data(), 1'b1);
      cycle(1'b1, 1'b1, {2'd2, 4'(t2)}, rand_data(), 1'b1);
    end
    first_bank = -1;
    for (int i = 0; i < 120; i++) begin
      idle(1'b1);
      if (o_valid && first_bank < 0) first_bank = int'(o_bank);
    end
    chk("interleave_first_bank", 32'(first_bank), 32'd1);
    drain(100);

    // Backpressure: stall 7 cycles on beat 5.
    fill_row(0, 1'b1);
    stalled = 0; stall_left = 0; n_hs = 0;
    for (int i = 0; i < 120; i++) begin
      if (!stalled && m_valid && m_beat == 4'd5) begin
        stalled = 1;
        stall_left = 7;
      end
      rdy = (stall_left == 0);
      if (m_valid && rdy) n_hs++;
      idle(rdy);
      if (stall_left > 0) begin
        chk("stall_beat", 32'(o_beat), 32'd5);
        chk("stall_valid", 32'(o_valid), 32'd1);
        stall_left--;
      end
    end
    chk("stall_handshakes", 32'(n_hs), 32'd12);

    // Errors: out-of-range beat, then a write to a queued bank.
    cycle(1'b1, 1'b1, 6'h0C, rand_data(), 1'b1);
    idle(1'b1);
    chk("err_addr_set", 32'(o_err_addr), 32'd1);
    chk("err_overrun_clear", 32'(o_err_overrun), 32'd0);
    fill_row(0, 1'b0);
    idle(1'b0);
    d = '1;
    cycle(1'b1, 1'b1, 6'h00, d, 1'b0);
    idle(1'b1);
    chk("err_overrun_set", 32'(o_err_overrun), 32'd1);
    drain(100);

    // Duplicate write: bank 3 beat 3 written 0x1111 then 0x2222.
    cycle(1'b1, 1'b1, {2'd3, 4'd3}, {64{16'h1111}}, 1'b1);
    for (int t2 = 0; t2 < BPR; t2++)
      cycle(1'b1, 1'b1, {2'd3, 4'(t2)}, (t2 == 3) ? {64{16'h2222}} : lane_data(16 * t2), 1'b1);
    dup_seen = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1'b1);
      if (o_valid && o_bank == 2'd3 && o_beat == 4'd3) begin
        dup_seen++;
        chk_data("dup_beat3", o_data_flat, {64{16'h2222}});
      end
    end
    chk("dup_seen_once", 32'(dup_seen), 32'd1);

    // Reset during SEND on beat 4 with bank 1 queued.
    fill_row(0, 1'b0);
    fill_row(1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      if (m_valid && m_beat == 4'd4) break;
      idle(1'b1);
    end
    idle(1'b0);
    chk("pre_reset_valid", 32'(o_valid), 32'd1);
    chk("pre_reset_beat", 32'(o_beat), 32'd4);
    chk("pre_reset_queue", 32'(m_q.size()), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_valid_now", 32'(o_valid), 32'd0);
    chk("rst_free_now", 32'(o_bank_free), 32'hF);
    model_reset();
    i_en = 0; i_res_valid = 0; i_ready = 1;
    for (int i = 0; i < 40; i++) idle(1'b1);

    // Randomized phase.
    verbose = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      en  = ($urandom_range(0, 9) != 0);
      vld = ($urandom_range(0, 3) != 0);
      r   = int'($urandom_range(0, 39));
      t   = int'($urandom_range(0, BPR - 1));
      b   = int'($urandom_range(0, 3));
      if (r == 0) begin
        t = int'($urandom_range(BPR, 15));
      end else if (r > 1) begin
        if (m_free == 4'h0) vld = 0;
        else while (!m_free[b]) b = (b + 1) % 4;
      end
      a = {2'(b), 4'(t)};
      cycle(en, vld, a, rand_data(), rdy);
    end
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
